// File: rtl/vector_mac.sv
// vector_mac: sign-magnitude dot-product engine.
//
// Computes result = bias + sum(w_i * x_i) over a vector of len pairs. All
// operands and the accumulator are sign-magnitude (MSB is the sign). The
// accumulator saturates at +/-(2^(ACC_W-1)-1), and sat records whether that
// clipping happened at any point in the current vector.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      begin a new vector (only honoured in IDLE)
//   len        number of pairs, sampled with start
//   bias       initial accumulator value, sampled with start
//   in_valid   data/weight pair present
//   in_ready   pair accepted this cycle (state ACC)
//   data       operand x_i
//   weight     operand w_i
//   out_valid  result available (state HOLD)
//   out_ready  consumer accepts result
//   result     accumulator value
//   sat        accumulator clipped at least once during this vector
//   busy       high in ACC and HOLD
//
// ACC_W must be at least 2*DATA_W-1 so that one product magnitude fits in
// the accumulator magnitude field.
module vector_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 21,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ACC_W-1:0]  bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] weight,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  result,
    output logic              sat,
    output logic              busy
);

    localparam int MAG_W  = ACC_W - 1;
    localparam int PROD_W = 2 * DATA_W - 2;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [LEN_W-1:0]   remaining;
    logic               sat_flag;

    logic [PROD_W-1:0]  prod_mag;
    logic               prod_sign;
    logic [ACC_W:0]     acc_next;   // {clipped, new accumulator}

    // Sign-magnitude accumulate with saturation. Returns {clipped, value}.
    // A zero-magnitude product is a no-op so that a "-0" operand can never
    // disturb the accumulator sign; an exact-zero difference is forced to +0.
    function automatic logic [ACC_W:0] sm_accumulate(
        input logic [ACC_W-1:0]  a,
        input logic              p_sign,
        input logic [PROD_W-1:0] p_mag
    );
        logic             a_sign;
        logic [MAG_W-1:0] a_mag;
        logic [MAG_W-1:0] pm;
        logic [MAG_W:0]   sum;
        logic [MAG_W-1:0] diff;
        logic             sign;
        a_sign = a[ACC_W-1];
        a_mag  = a[MAG_W-1:0];
        pm     = MAG_W'(p_mag);
        sum    = '0;
        diff   = '0;
        sign   = 1'b0;
        if (p_mag == '0) begin
            sm_accumulate = {1'b0, a};
        end else if (a_sign == p_sign) begin
            sum = {1'b0, a_mag} + {1'b0, pm};
            // Carry out means the sum passed the all-ones magnitude limit.
            if (sum[MAG_W])
                sm_accumulate = {1'b1, a_sign, {MAG_W{1'b1}}};
            else
                sm_accumulate = {1'b0, a_sign, sum[MAG_W-1:0]};
        end else begin
            if (a_mag >= pm) begin
                diff = a_mag - pm;
                sign = (diff == '0) ? 1'b0 : a_sign;
            end else begin
                diff = pm - a_mag;
                sign = p_sign;
            end
            sm_accumulate = {1'b0, sign, diff};
        end
    endfunction

    // Bias loaded at start: -0 becomes +0.
    function automatic logic [ACC_W-1:0] sm_normalise(input logic [ACC_W-1:0] v);
        if (v[MAG_W-1:0] == '0)
            sm_normalise = '0;
        else
            sm_normalise = v;
    endfunction

    assign prod_mag  = PROD_W'(data[DATA_W-2:0]) * PROD_W'(weight[DATA_W-2:0]);
    assign prod_sign = data[DATA_W-1] ^ weight[DATA_W-1];
    assign acc_next  = sm_accumulate(acc, prod_sign, prod_mag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            sat_flag  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= sm_normalise(bias);
                        sat_flag  <= 1'b0;
                        remaining <= len;
                        state     <= (len != '0) ? ACC : HOLD;
                    end
                end
                ACC: begin
                    // No beat means everything holds; there is no timeout.
                    if (in_valid) begin
                        acc       <= acc_next[ACC_W-1:0];
                        sat_flag  <= sat_flag | acc_next[ACC_W];
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1))
                            state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Flags decode straight from the state register, so reset clears them
    // in the same cycle it is asserted.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign result    = acc;
    assign sat       = sat_flag;

endmodule

// File: tb/tb_vector_mac.sv
// Directed testbench for vector_mac (DATA_W=8, ACC_W=21, LEN_W=10).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_vector_mac;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  len;
    logic [20:0] bias;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  data;
    logic [7:0]  weight;
    logic        out_valid;
    logic        out_ready;
    logic [20:0] result;
    logic        sat;
    logic        busy;

    int total = 0;
    int bad   = 0;

    vector_mac #(
        .DATA_W(8),
        .ACC_W (21),
        .LEN_W (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .bias     (bias),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data     (data),
        .weight   (weight),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .sat      (sat),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_vec(input logic [20:0] b, input logic [9:0] n);
        start = 1'b1;
        bias  = b;
        len   = n;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d, input logic [7:0] w);
        in_valid = 1'b1;
        data     = d;
        weight   = w;
        tick();
        in_valid = 1'b0;
    endtask

    // Bounded wait for out_valid; an expired bound counts as a failure.
    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        if (!out_valid)
            chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        bias      = '0;
        in_valid  = 1'b0;
        data      = '0;
        weight    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_result",    32'(result),    32'd0);
        chk("rst_sat",       32'(sat),       32'd0);
        rst = 1'b0;
        tick();

        // 12 - 10 - 1 = 1
        start_vec(21'h000000, 10'd3);
        chk("v1_busy",     32'(busy),     32'd1);
        chk("v1_in_ready", 32'(in_ready), 32'd1);
        beat(8'h03, 8'h04);
        chk("v1_acc1", 32'(result), 32'h000000C);
        beat(8'h82, 8'h05);
        chk("v1_acc2", 32'(result), 32'h0000002);
        chk("v1_not_done", 32'(out_valid), 32'd0);
        beat(8'h01, 8'h81);
        chk("v1_out_valid", 32'(out_valid), 32'd1);
        chk("v1_in_ready_low", 32'(in_ready), 32'd0);
        chk("v1_result", 32'(result), 32'h000001);
        chk("v1_sat",    32'(sat),    32'd0);
        take_out();
        chk("v1_idle_out_valid", 32'(out_valid), 32'd0);
        chk("v1_idle_busy",      32'(busy),      32'd0);

        // 5 - 12 = -7
        start_vec(21'h000005, 10'd1);
        beat(8'h83, 8'h04);
        chk("v2_out_valid", 32'(out_valid), 32'd1);
        chk("v2_result", 32'(result), 32'h100007);
        take_out();

        // 6 - 6 must give +0, not -0
        start_vec(21'h000006, 10'd1);
        beat(8'h82, 8'h03);
        chk("v2b_zero", 32'(result), 32'h000000);
        take_out();

        // 66 * 16129 = 1064514 > 1048575: clips on the last beat
        start_vec(21'h000000, 10'd66);
        for (int i = 0; i < 65; i++)
            beat(8'h7F, 8'h7F);
        chk("v3_acc65", 32'(result), 32'd1048385);
        chk("v3_sat_before", 32'(sat), 32'd0);
        beat(8'h7F, 8'h7F);
        wait_out("v3");
        chk("v3_result", 32'(result), 32'h0FFFFF);
        chk("v3_sat",    32'(sat),    32'd1);
        take_out();
        chk("v3_sat_persists", 32'(sat), 32'd1);

        // len 0: straight to HOLD, bias passes through; sat cleared by start
        start_vec(21'h100003, 10'd0);
        chk("v4_out_valid", 32'(out_valid), 32'd1);
        chk("v4_in_ready",  32'(in_ready),  32'd0);
        chk("v4_result",    32'(result),    32'h100003);
        chk("v4_sat_clear", 32'(sat),       32'd0);
        take_out();
        start_vec(21'h100000, 10'd0);
        chk("v4_neg_zero", 32'(result), 32'h000000);
        take_out();

        // Backpressure, ignored starts and a -0 operand
        start_vec(21'h000000, 10'd3);
        beat(8'h02, 8'h03);
        tick();
        tick();
        chk("v5_gap_hold", 32'(result), 32'h000006);
        chk("v5_gap_ready", 32'(in_ready), 32'd1);
        start_vec(21'h000077, 10'd0);
        chk("v5_start_in_acc", 32'(result), 32'h000006);
        chk("v5_still_acc", 32'(in_ready), 32'd1);
        beat(8'h80, 8'h05);
        chk("v5_neg_zero_prod", 32'(result), 32'h000006);
        tick();
        beat(8'h85, 8'h02);
        chk("v5_out_valid", 32'(out_valid), 32'd1);
        chk("v5_result", 32'(result), 32'h100004);
        for (int i = 0; i < 5; i++) begin
            if (i == 2)
                start_vec(21'h000011, 10'd2);
            else
                tick();
        end
        chk("v5_hold_valid",  32'(out_valid), 32'd1);
        chk("v5_hold_result", 32'(result),    32'h100004);
        take_out();
        chk("v5_released", 32'(busy), 32'd0);

        // Reset mid-vector
        start_vec(21'h000000, 10'd4);
        beat(8'h05, 8'h05);
        beat(8'h06, 8'h06);
        #2;
        rst = 1'b1;
        #1;
        chk("v6_rst_result",   32'(result),    32'd0);
        chk("v6_rst_busy",     32'(busy),      32'd0);
        chk("v6_rst_in_ready", 32'(in_ready),  32'd0);
        chk("v6_rst_valid",    32'(out_valid), 32'd0);
        chk("v6_rst_sat",      32'(sat),       32'd0);
        tick();
        rst = 1'b0;
        tick();
        start_vec(21'h000000, 10'd2);
        beat(8'h02, 8'h02);
        beat(8'h03, 8'h03);
        chk("v6_out_valid", 32'(out_valid), 32'd1);
        chk("v6_result", 32'(result), 32'h00000D);
        take_out();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
